// File: rtl/bg_tile_fetcher.sv
// bg_tile_fetcher
//   Background tile fetch sequencer for the PPU. Runs the 8-dot fetch
//   pipeline (nametable, attribute, pattern low, pattern high). Once per
//   tile it hands the captured bytes to holding registers. It then
//   serialises them one bit per dot into the four background shift
//   registers, while the next tile is being fetched.
//
// Ports
//   i_clk           PPU clock
//   i_reset         synchronous, active-high reset
//   i_ce            dot enable; state advances only on enabled dots
//   i_fetch_en      rendering enabled and dot inside a fetch region
//   i_v[14:0]       VRAM address register (fineY, NT, coarseY, coarseX)
//   i_pattern_sel   background pattern table select
//   i_vram_data[7:0] VRAM read data, valid on the dot after the address
//   o_vram_addr[13:0] VRAM read address
//   o_vram_rd       read strobe (phases 0, 2, 4, 6)
//   o_inc_coarse_x  one-dot pulse at the end of a tile fetch
//   o_shift         shift control for all four shift registers
//   o_load          load control for all four shift registers
//   o_pat_lo_bit    serial pattern low plane bit
//   o_pat_hi_bit    serial pattern high plane bit
//   o_attr_lo_bit   serial palette bit 0
//   o_attr_hi_bit   serial palette bit 1

module bg_tile_fetcher (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_fetch_en,
    input  logic [14:0] i_v,
    input  logic        i_pattern_sel,
    input  logic [7:0]  i_vram_data,
    output logic [13:0] o_vram_addr,
    output logic        o_vram_rd,
    output logic        o_inc_coarse_x,
    output logic        o_shift,
    output logic        o_load,
    output logic        o_pat_lo_bit,
    output logic        o_pat_hi_bit,
    output logic        o_attr_lo_bit,
    output logic        o_attr_hi_bit
);

    typedef enum logic [2:0] {
        PH_NT_ADDR = 3'd0,
        PH_NT_DATA = 3'd1,
        PH_AT_ADDR = 3'd2,
        PH_AT_DATA = 3'd3,
        PH_LO_ADDR = 3'd4,
        PH_LO_DATA = 3'd5,
        PH_HI_ADDR = 3'd6,
        PH_HI_DATA = 3'd7
    } phase_t;

    phase_t      phase;
    phase_t      phase_next;
    logic [14:0] r_v;
    logic [7:0]  r_nt;
    logic [1:0]  r_at2;
    logic [7:0]  r_plo;
    logic [7:0]  hold_lo;
    logic [7:0]  hold_hi;
    logic [1:0]  hold_at;
    logic        valid;

    logic        active;
    logic [2:0]  bit_idx;
    logic [7:0]  at_shifted;

    // Attribute byte holds four 2-bit palettes; quadrant picked by
    // coarseY bit 1 and coarseX bit 1 of the snapshot.
    assign at_shifted = i_vram_data >> {r_v[6], r_v[1], 1'b0};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase   <= PH_NT_ADDR;
            r_v     <= '0;
            r_nt    <= '0;
            r_at2   <= '0;
            r_plo   <= '0;
            hold_lo <= '0;
            hold_hi <= '0;
            hold_at <= '0;
            valid   <= 1'b0;
        end else if (i_ce) begin
            if (!i_fetch_en) begin
                phase <= PH_NT_ADDR;
                valid <= 1'b0;
            end else begin
                phase <= phase_next;
                case (phase)
                    PH_NT_ADDR: r_v   <= i_v;
                    PH_NT_DATA: r_nt  <= i_vram_data;
                    PH_AT_DATA: r_at2 <= at_shifted[1:0];
                    PH_LO_DATA: r_plo <= i_vram_data;
                    PH_HI_DATA: begin
                        // High plane is taken straight off the bus on the
                        // same edge that commits the tile.
                        hold_lo <= r_plo;
                        hold_hi <= i_vram_data;
                        hold_at <= r_at2;
                        valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        phase_next     = PH_NT_ADDR;
        o_vram_addr    = '0;
        o_vram_rd      = 1'b0;
        o_inc_coarse_x = 1'b0;

        active = i_ce & i_fetch_en & ~i_reset;

        case (phase)
            PH_NT_ADDR: begin
                phase_next  = PH_NT_DATA;
                // Snapshot is taken on this dot, so use the live register.
                o_vram_addr = {2'b10, i_v[11:0]};
                o_vram_rd   = active;
            end
            PH_NT_DATA: begin
                phase_next  = PH_AT_ADDR;
                o_vram_addr = {2'b10, r_v[11:0]};
            end
            PH_AT_ADDR: begin
                phase_next  = PH_AT_DATA;
                o_vram_addr = {2'b10, r_v[11:10], 4'b1111, r_v[9:7], r_v[4:2]};
                o_vram_rd   = active;
            end
            PH_AT_DATA: begin
                phase_next  = PH_LO_ADDR;
                o_vram_addr = {2'b10, r_v[11:10], 4'b1111, r_v[9:7], r_v[4:2]};
            end
            PH_LO_ADDR: begin
                phase_next  = PH_LO_DATA;
                o_vram_addr = {1'b0, i_pattern_sel, r_nt, 1'b0, r_v[14:12]};
                o_vram_rd   = active;
            end
            PH_LO_DATA: begin
                phase_next  = PH_HI_ADDR;
                o_vram_addr = {1'b0, i_pattern_sel, r_nt, 1'b0, r_v[14:12]};
            end
            PH_HI_ADDR: begin
                phase_next  = PH_HI_DATA;
                o_vram_addr = {1'b0, i_pattern_sel, r_nt, 1'b1, r_v[14:12]};
                o_vram_rd   = active;
            end
            PH_HI_DATA: begin
                phase_next     = PH_NT_ADDR;
                o_vram_addr    = {1'b0, i_pattern_sel, r_nt, 1'b1, r_v[14:12]};
                o_inc_coarse_x = active;
            end
            default: phase_next = PH_NT_ADDR;
        endcase

        if (i_reset) begin
            o_vram_addr = '0;
        end
    end

    // MSB (leftmost pixel) goes out first: index 7 - phase.
    assign bit_idx       = ~3'(phase);
    assign o_shift       = i_ce & i_fetch_en & ~i_reset;
    assign o_load        = o_shift & valid;
    assign o_pat_lo_bit  = valid & ~i_reset & hold_lo[bit_idx];
    assign o_pat_hi_bit  = valid & ~i_reset & hold_hi[bit_idx];
    assign o_attr_lo_bit = valid & ~i_reset & hold_at[0];
    assign o_attr_hi_bit = valid & ~i_reset & hold_at[1];

endmodule
